muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller for the multi-cycle MULT/MULTU/DIV/DIVU unit in the EX stage of the pipelined MIPS core. It accepts one HI/LO operation at a time and runs either a fixed-latency multiplier or a 32-iteration radix-2 divider. While the operation is in progress it holds the pipeline with a stall. On completion it writes HI/LO for one cycle, and it aborts cleanly on an exception flush.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
MUL_LAT, 2, number of cycles in MUL state (1..8)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  EX holds a MULT/MULTU/DIV/DIVU this cycle
op_i  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
src_a  in  WIDTH  rs operand
src_b  in  WIDTH  rt operand
flush_i  in  1  exception/ERET flush of EX
stall_o  out  1  hold IF/ID/EX
busy_o  out  1  state != IDLE
hilo_we_o  out  1  one-cycle HI/LO write strobe
hi_o  out  WIDTH  HI result (product high word / remainder)
lo_o  out  WIDTH  LO result (product low word / quotient)

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- States: IDLE, MUL, DIV, DONE. On reset: state=IDLE, cnt=0, hilo_we_o=0, hi_o=0, lo_o=0, busy_o=0, stall_o=0.
- IDLE with valid_i=1 and flush_i=0 (start cycle T):
  - Latch op, the operands, and the operand signs.
  - For signed ops, take magnitudes of both operands.
  - Go to MUL for op 0/1, or DIV for op 2/3. Clear cnt.
- MUL: stay MUL_LAT cycles (T+1..T+MUL_LAT), then go to DONE.
  - Product is the full 2*WIDTH-bit result.
  - MULT is signed, MULTU is unsigned.
  - {hi_o, lo_o} = product.
- DIV: 32 restoring iterations, one per cycle (T+1..T+32), cnt counts 0..31.
  - After the iteration at cnt=31, go to DONE.
  - Signed result correction:
    - quotient sign = sign(a) XOR sign(b)
    - remainder sign = sign(a)
    - lo_o = quotient, hi_o = remainder.
  - Divide by zero: the full 32 cycles still run; result is forced to lo_o=32'hFFFFFFFF and hi_o=src_a as latched. This holds for both DIV and DIVU.
- DONE (T+MUL_LAT+1 or T+33):
  - hilo_we_o=1 for exactly this cycle; hi_o/lo_o valid and stable.
  - stall_o=0; go to IDLE next cycle.
  - valid_i in DONE is ignored, because it is the same instruction leaving EX.
- stall_o (combinational) = ~flush_i & ((state==IDLE & valid_i) | state==MUL | state==DIV).
  - Stall is high from T through the last compute cycle.
- hi_o/lo_o hold their last result outside DONE. hilo_we_o is a registered-state decode.
- Flush:
  - flush_i in IDLE: no start.
  - flush_i in MUL or DIV: abort, go to IDLE next cycle, no hilo_we_o, stall_o drops the same cycle.
  - flush_i in DONE: the write still occurs, because the instruction has already committed its HI/LO result.
- rst in any state forces reset values on the next edge, regardless of flush_i or valid_i.
- Back-to-back ops: a second op arriving the cycle after DONE starts normally from IDLE. Minimum spacing is one DONE cycle plus one IDLE cycle.

Decomposition:
- defines.vh (shared) holds:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op encodings (2-bit)
  - MD_IDLE/MD_MUL/MD_DIV/MD_DONE state encodings
  - the decoder's mapping from EXE_MULT/EXE_MULTU/EXE_DIV/EXE_DIVU funct to op_i
- One sub-module, div_radix2: per-cycle restoring step.
  - Inputs: partial remainder, dividend shift register, divisor.
  - Outputs: next remainder, next quotient bit.
- The controller owns the FSM, the counter, sign handling, and the multiplier pipeline registers.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'h2 -> stall_o high T..T+2; hilo_we_o at T+3; hi_o=32'h1, lo_o=32'hFFFFFFFE.
- MULT a=-3 (32'hFFFFFFFD), b=5 -> hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFF1 (-15).
- DIV a=-7, b=2 -> stall_o high T..T+32; hilo_we_o at T+33; lo_o=32'hFFFFFFFD (-3), hi_o=32'hFFFFFFFF (-1). DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU a=32'h1234, b=0 -> after 33 cycles lo_o=32'hFFFFFFFF, hi_o=32'h1234, one hilo_we_o pulse.
- DIV started, then flush_i at T+10 -> stall_o=0 at T+10, IDLE at T+11, no hilo_we_o; a MULTU 6*7 issued at T+12 completes at T+15 with lo_o=42.
- rst asserted at T+5 of a DIV -> next cycle: all outputs 0, busy_o=0; a fresh DIVU 9/3 then gives lo_o=3, hi_o=0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Operand signs captured at start; drive the final sign correction.
  typedef struct packed {
    logic sign_a;
    logic sign_b;
  } md_sign_t;

  localparam logic [5:0] EXE_MULT  = 6'h18;
  localparam logic [5:0] EXE_MULTU = 6'h19;
  localparam logic [5:0] EXE_DIV   = 6'h1A;
  localparam logic [5:0] EXE_DIVU  = 6'h1B;

  // Decoder mapping from SPECIAL funct to op_i.
  function automatic md_op_e md_funct_to_op(input logic [5:0] funct);
    md_op_e op;
    case (funct)
      EXE_MULTU: op = OP_MULTU;
      EXE_DIV:   op = OP_DIV;
      EXE_DIVU:  op = OP_DIVU;
      default:   op = OP_MULT;
    endcase
    return op;
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dq,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_dq[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: stalls the pipe, runs the op, writes HI/LO once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  md_sign_t           r_sign;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dq;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start;
  logic               w_mul_done;
  logic               w_div_done;
  logic               w_stall;
  md_op_e             w_op;
  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_dq_nxt;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;
  logic               w_div_zero;

  assign w_op     = md_op_e'(op_i);
  assign w_signed = md_is_signed(w_op);
  assign w_sign_a = w_signed & src_a[WIDTH-1];
  assign w_sign_b = w_signed & src_b[WIDTH-1];

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_mul_done  = 1'b0;
    w_div_done  = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          w_start     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = md_is_div(w_op) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == MUL_LAST) begin
            w_mul_done  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == DIV_LAST) begin
            w_div_done  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and iteration counter; the counter idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_MUL || r_state == ST_DIV) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  div_radix2 #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_rem),
    .i_dq      (r_dq),
    .i_divisor (r_b_mag),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_dq_nxt   = {r_dq[WIDTH-2:0], w_qbit};
  assign w_prod_mag = (2*WIDTH)'(r_a_mag) * (2*WIDTH)'(r_b_mag);
  assign w_prod     = (r_sign.sign_a ^ r_sign.sign_b) ? -w_prod_mag : w_prod_mag;
  assign w_div_zero = (r_b_mag == '0);
  assign w_quo      = (r_sign.sign_a ^ r_sign.sign_b) ? -w_dq_nxt : w_dq_nxt;
  assign w_rmd      = r_sign.sign_a ? -w_rem_nxt : w_rem_nxt;

  // Operand capture, divider iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign  <= '0;
      r_a_raw <= '0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_rem   <= '0;
      r_dq    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_start) begin
        r_sign  <= '{sign_a: w_sign_a, sign_b: w_sign_b};
        r_a_raw <= src_a;
        r_a_mag <= w_sign_a ? -src_a : src_a;
        r_b_mag <= w_sign_b ? -src_b : src_b;
        r_rem   <= '0;
        r_dq    <= w_sign_a ? -src_a : src_a;
      end else if (r_state == ST_DIV) begin
        r_rem <= w_rem_nxt;
        r_dq  <= w_dq_nxt;
      end
      if (w_mul_done) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end else if (w_div_done) begin
        r_hi <= w_div_zero ? r_a_raw : w_rmd;
        r_lo <= w_div_zero ? '1 : w_quo;
      end
    end
  end

  assign stall_o   = w_stall;
  assign busy_o    = (r_state != ST_IDLE);
  assign hilo_we_o = (r_state == ST_DONE);
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue, checked on each write strobe.
module tb_muldiv_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MUL_LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             hilo_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .op_i      (op_i),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  // Reference result: {hi, lo} computed with 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {(a % b), (a / b)};
      end
    endcase
  endfunction

  // Scoreboard: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && hilo_we_o) begin
      logic [63:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write hi=%h lo=%h with no op outstanding", hi_o, lo_o);
      end else begin
        e = exp_q.pop_front();
        if ({hi_o, lo_o} !== e) begin
          n_fail++;
          $display("FAIL result got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Issue one op from IDLE and follow it to its DONE cycle; returns at DONE negedge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n, lat;
    bit stall_ok;
    lat = (op[1]) ? 33 : MUL_LAT + 1;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_before busy_o=%b expected 0", name, busy_o);
    end
    valid_i = 1'b1; op_i = op; src_a = a; src_b = b;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_stall_T stall_o=%b expected 1", name, stall_o);
    end
    @(negedge clk);
    valid_i = 1'b0; src_a = $urandom; src_b = $urandom;
    n = 1;
    stall_ok = 1'b1;
    while (hilo_we_o !== 1'b1 && n < 100) begin
      if (stall_o !== 1'b1 || busy_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!stall_ok) begin
      n_fail++;
      $display("FAIL %s_stall_hold stall/busy dropped before completion", name);
    end
    n_cmp++;
    if (n != lat) begin
      n_fail++;
      $display("FAIL %s_latency got %0d cycles expected %0d", name, n, lat);
    end
    n_cmp++;
    if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_flags stall_o=%b busy_o=%b expected 0/1", name, stall_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; op_i = 2'd2; src_a = 32'd5; src_b = 32'd1; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, hilo_we_o, hi_o, lo_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs busy=%b we=%b hi=%h lo=%h expected all 0", busy_o, hilo_we_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(2'd1, 32'hFFFF_FFFF, 32'h2, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
  endtask

  task automatic test_div();
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "div_negdiv");
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max");
  endtask

  task automatic test_div_zero();
    run_op(2'd3, 32'h1234, 32'd0, "divu_zero");
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, "div_zero");
  endtask

  // Flush of an in-flight DIV at T+10, then a MULTU from T+12.
  task automatic test_flush();
    @(negedge clk);
    valid_i = 1'b1; op_i = 2'd2; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_stall_drop stall_o=%b busy_o=%b expected 0/1", stall_o, busy_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || hilo_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_to_idle busy_o=%b we=%b expected 0/0", busy_o, hilo_we_o);
    end
    run_op(2'd1, 32'd6, 32'd7, "multu_after_flush");
  endtask

  // Flush while idle blocks the start; flush in DONE still writes.
  task automatic test_flush_edges();
    @(negedge clk);
    valid_i = 1'b1; op_i = 2'd1; src_a = 32'd3; src_b = 32'd3; flush_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_stall stall_o=%b expected 0", stall_o);
    end
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_nostart busy_o=%b expected 0", busy_o);
    end
    run_op(2'd0, 32'd11, 32'hFFFF_FFFF, "mult_flush_done");
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    valid_i = 1'b1; op_i = 2'd2; src_a = 32'd50; src_b = 32'd5;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; flush_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, stall_o, hilo_we_o, hi_o, lo_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid busy=%b stall=%b we=%b hi=%h lo=%h expected all 0", busy_o, stall_o, hilo_we_o, hi_o, lo_o);
    end
    run_op(2'd3, 32'd9, 32'd3, "divu_after_rst");
  endtask

  // valid_i during DONE belongs to the departing instruction and must not start.
  task automatic test_done_ignore();
    run_op(2'd1, 32'd12, 32'd12, "multu_done_valid");
    valid_i = 1'b1; op_i = 2'd1;
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_valid_ignored busy_o=%b expected 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(op, a, b, "b2b");
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = 2'd0; src_a = '0; src_b = '0; flush_i = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_flush_edges();
    test_rst_mid();
    test_done_ignore();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain %0d results never written, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
